uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver for the interface block. It runs on one system clock gated by a baud-oversample strobe and majority-votes three samples per bit. It supports 1–16 data bits, optional parity and 1 or 2 stop bits, and detects break conditions. Received frames go to downstream logic through a valid/ready register, with overrun reporting.

---
 rtl/uart_rx_os.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop line synchronizer, 3-sample majority vote
// at mid-bit, 1..16 data bits, optional parity, 1 or 2 stop bits, break
// detection, and a valid/ready output register with overrun reporting.
module uart_rx_os #(
    parameter int OVERSAMPLE = 8,
    parameter int MAX_WIDTH  = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_sample_en,
    input  logic [1:0]           i_parity,
    input  logic [3:0]           i_data_width,
    input  logic                 i_stop_bits,
    input  logic                 i_data,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [MAX_WIDTH-1:0] o_data,
    output logic                 o_error_parity,
    output logic                 o_error_stop_bit,
    output logic                 o_break,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
    } state_t;

    state_t                 state_q;
    logic [1:0]             sync_q;
    logic [TW-1:0]          t_q;
    logic                   s0_q, s1_q;
    logic [3:0]             bit_q;
    logic [3:0]             last_bit_q;
    logic                   par_en_q, par_odd_q, two_stop_q, stop2_q;
    logic                   acc_q, zero_q, perr_q, serr_q, brk_q;
    logic [MAX_WIDTH-1:0]   data_q;

    logic                   rx;
    logic                   maj;
    logic                   dec_tick;
    logic                   end_tick;
    logic                   commit_d;
    logic                   frame_brk_d;
    logic                   frame_serr_d;

    assign rx       = sync_q[1];
    assign maj      = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
    assign dec_tick = i_sample_en && (t_q == T_DEC);
    assign end_tick = i_sample_en && (t_q == T_LAST);

    // Frame completes on the decision tick of the last stop bit.
    assign commit_d     = dec_tick && (state_q == S_STOP) && (!two_stop_q || stop2_q);
    // Break is judged on the first stop bit; with two stop bits it was latched then.
    assign frame_brk_d  = stop2_q ? brk_q : (zero_q & ~maj);
    assign frame_serr_d = serr_q | ~maj | frame_brk_d;

    assign o_busy = (state_q != S_IDLE);

    // Synchronizer, bit-timing FSM and output register with handshake.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q          <= S_IDLE;
            sync_q           <= 2'b11;
            t_q              <= '0;
            s0_q             <= 1'b0;
            s1_q             <= 1'b0;
            bit_q            <= '0;
            last_bit_q       <= '0;
            par_en_q         <= 1'b0;
            par_odd_q        <= 1'b0;
            two_stop_q       <= 1'b0;
            stop2_q          <= 1'b0;
            acc_q            <= 1'b0;
            zero_q           <= 1'b0;
            perr_q           <= 1'b0;
            serr_q           <= 1'b0;
            brk_q            <= 1'b0;
            data_q           <= '0;
            o_valid          <= 1'b0;
            o_data           <= '0;
            o_error_parity   <= 1'b0;
            o_error_stop_bit <= 1'b0;
            o_break          <= 1'b0;
            o_overrun        <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_data};

            // Handshake runs every clock; a commit in the same cycle wins.
            if (o_valid && i_ready) begin
                o_valid   <= 1'b0;
                o_overrun <= 1'b0;
            end
            if (commit_d) begin
                if (!o_valid || i_ready) begin
                    o_valid          <= 1'b1;
                    o_data           <= frame_brk_d ? '0 : data_q;
                    o_error_parity   <= perr_q;
                    o_error_stop_bit <= frame_serr_d;
                    o_break          <= frame_brk_d;
                end else begin
                    o_overrun <= 1'b1;
                end
            end

            if (i_sample_en) begin
                if (t_q == T_S0) s0_q <= rx;
                if (t_q == T_S1) s1_q <= rx;

                case (state_q)
                    S_IDLE: begin
                        t_q <= '0;
                        if (!rx) state_q <= S_START;
                    end
                    S_START: begin
                        t_q <= (t_q == T_LAST) ? '0 : t_q + TW'(1);
                        if (end_tick) begin
                            state_q <= S_DATA;
                            bit_q   <= '0;
                        end
                        if (dec_tick) begin
                            if (maj) begin
                                // Glitch: start bit did not hold low at mid-bit.
                                state_q <= S_IDLE;
                                t_q     <= '0;
                            end else begin
                                last_bit_q <= i_data_width - 4'd1;
                                par_en_q   <= i_parity[1];
                                par_odd_q  <= i_parity[0];
                                two_stop_q <= i_stop_bits;
                                data_q     <= '0;
                                acc_q      <= 1'b0;
                                zero_q     <= 1'b1;
                                perr_q     <= 1'b0;
                                serr_q     <= 1'b0;
                                brk_q      <= 1'b0;
                            end
                        end
                    end
                    S_DATA: begin
                        t_q <= (t_q == T_LAST) ? '0 : t_q + TW'(1);
                        if (dec_tick) begin
                            data_q[bit_q] <= maj;
                            acc_q         <= acc_q ^ maj;
                            zero_q        <= zero_q & ~maj;
                        end
                        if (end_tick) begin
                            if (bit_q == last_bit_q) begin
                                state_q <= par_en_q ? S_PARITY : S_STOP;
                                stop2_q <= 1'b0;
                            end else begin
                                bit_q <= bit_q + 4'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        t_q <= (t_q == T_LAST) ? '0 : t_q + TW'(1);
                        if (dec_tick) begin
                            perr_q <= acc_q ^ maj ^ par_odd_q;
                            zero_q <= zero_q & ~maj;
                        end
                        if (end_tick) begin
                            state_q <= S_STOP;
                            stop2_q <= 1'b0;
                        end
                    end
                    S_STOP: begin
                        t_q <= (t_q == T_LAST) ? '0 : t_q + TW'(1);
                        if (dec_tick) begin
                            serr_q <= serr_q | ~maj;
                            if (!stop2_q) brk_q <= zero_q & ~maj;
                        end
                        if (commit_d) begin
                            // Leave at once so a back-to-back start edge is not missed.
                            state_q <= frame_brk_d ? S_WAIT : S_IDLE;
                            t_q     <= '0;
                        end else if (end_tick) begin
                            stop2_q <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        t_q <= '0;
                        if (rx) state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        t_q     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed frames plus randomized frames, with expected
// results queued by the sender and popped by an independent output monitor.
module tb_uart_rx_os;

    localparam int OS = 8;

    logic        clk = 1'b0;
    logic        i_reset, i_sample_en, i_stop_bits, i_data, i_ready;
    logic [1:0]  i_parity;
    logic [3:0]  i_data_width;
    logic        o_valid, o_error_parity, o_error_stop_bit, o_break, o_overrun, o_busy;
    logic [15:0] o_data;

    uart_rx_os #(.OVERSAMPLE(OS), .MAX_WIDTH(16)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_sample_en(i_sample_en),
        .i_parity(i_parity), .i_data_width(i_data_width), .i_stop_bits(i_stop_bits),
        .i_data(i_data), .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data),
        .o_error_parity(o_error_parity), .o_error_stop_bit(o_error_stop_bit),
        .o_break(o_break), .o_overrun(o_overrun), .o_busy(o_busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        p;
        logic        s;
        logic        b;
    } exp_t;

    exp_t sb[$];
    int   npass = 0, ntot = 0, nacc = 0;
    bit   rand_strobe = 0, rand_ready = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: what a receiver must report for a given transmitted frame.
    function automatic exp_t model(input logic [15:0] d, input int w, input bit pen,
                                   input bit odd, input bit pbit, input int nstop,
                                   input bit s1, input bit s2);
        exp_t        e;
        logic [15:0] mask;
        logic [15:0] dm;
        mask = (w == 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
        dm   = d & mask;
        e.b  = (dm == 16'h0) && (!pen || !pbit) && !s1;
        e.p  = pen && ((($countones(dm) + int'(pbit) + int'(odd)) % 2) == 1);
        e.s  = !s1 || (nstop == 2 && !s2) || e.b;
        e.d  = e.b ? 16'h0 : dm;
        return e;
    endfunction

    // Hold the current line level for n strobe cycles.
    task automatic strobes(input int n);
        repeat (n) begin
            do begin
                @(negedge clk);
                i_sample_en = rand_strobe ? ($urandom_range(0, 3) != 0) : 1'b1;
            end while (!i_sample_en);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input bit b);
        i_data = b;
        strobes(OS);
    endtask

    task automatic send_frame(input logic [15:0] d, input int w, input bit pen, input bit odd,
                              input bit pbit, input int nstop, input bit s1, input bit s2,
                              input bit push);
        i_parity     = {pen, odd};
        i_data_width = 4'(w);
        i_stop_bits  = (nstop == 2);
        if (push) sb.push_back(model(d, w, pen, odd, pbit, nstop, s1, s2));
        send_bit(1'b0);
        for (int k = 0; k < w; k++) send_bit(d[k]);
        if (pen) send_bit(pbit);
        send_bit(s1);
        if (nstop == 2) send_bit(s2);
        i_data = 1'b1;
        strobes(2 * OS);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (o_valid && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (o_valid) begin
            ntot++;
            $display("FAIL drain_timeout: o_valid still %0b after %0d cycles", o_valid, k);
        end
    endtask

    // Output monitor: every accepted frame must match the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (!i_reset && o_valid && i_ready) begin
            nacc++;
            if (sb.size() == 0) begin
                ntot++;
                $display("FAIL unexpected_frame: got data=%h p=%0b s=%0b b=%0b expected none",
                         o_data, o_error_parity, o_error_stop_bit, o_break);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame", {13'h0, o_data, o_error_parity, o_error_stop_bit, o_break},
                      {13'h0, e.d, e.p, e.s, e.b});
            end
        end
    end

    // Random consumer back-pressure.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) i_ready = ($urandom_range(0, 1) == 1);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc0;
        i_reset = 1'b1; i_sample_en = 1'b1; i_data = 1'b1; i_ready = 1'b1;
        i_parity = 2'b00; i_data_width = 4'd8; i_stop_bits = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {o_valid, o_busy, o_overrun, o_error_parity, o_error_stop_bit,
              o_break, o_data}, 32'h0);
        i_reset = 1'b0;
        strobes(2 * OS);

        // 8N1 0xA5
        send_frame(16'h00A5, 8, 0, 0, 0, 1, 1, 1, 1);
        // 7E1 0x41, good then bad parity
        send_frame(16'h0041, 7, 1, 0, 0, 1, 1, 1, 1);
        send_frame(16'h0041, 7, 1, 0, 1, 1, 1, 1, 1);

        // Short start glitch must be rejected
        acc0 = nacc;
        i_data = 1'b0; strobes(2);
        i_data = 1'b1; strobes(3 * OS);
        check("glitch_busy", {31'h0, o_busy}, 32'h0);
        check("glitch_no_frame", nacc - acc0, 0);

        // Single-tick low at mid of data bit 3 of 0xFF
        i_parity = 2'b00; i_data_width = 4'd8; i_stop_bits = 1'b0;
        sb.push_back(model(16'h00FF, 8, 0, 0, 0, 1, 1, 1));
        send_bit(1'b0);
        for (int k = 0; k < 3; k++) send_bit(1'b1);
        i_data = 1'b1; strobes(4);
        i_data = 1'b0; strobes(1);
        i_data = 1'b1; strobes(3);
        for (int k = 4; k < 8; k++) send_bit(1'b1);
        send_bit(1'b1);
        strobes(2 * OS);

        // Overrun: two frames with no consumer
        drain();
        i_ready = 1'b0;
        send_frame(16'h0011, 8, 0, 0, 0, 1, 1, 1, 1);
        send_frame(16'h0022, 8, 0, 0, 0, 1, 1, 1, 0);
        check("overrun_flag", {31'h0, o_overrun}, 32'h1);
        check("overrun_held", {15'h0, o_valid, o_data}, {15'h0, 1'b1, 16'h0011});
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        check("after_accept", {30'h0, o_valid, o_overrun}, 32'h0);
        i_ready = 1'b1;

        // 8N2 with second stop low, then 16-bit word
        send_frame(16'h003C, 8, 0, 0, 0, 2, 1, 0, 1);
        send_frame(16'hBEEF, 16, 0, 0, 0, 1, 1, 1, 1);

        // Break: line low for 12 bit times
        i_parity = 2'b00; i_data_width = 4'd8; i_stop_bits = 1'b0;
        acc0 = nacc;
        sb.push_back(model(16'h0000, 8, 0, 0, 0, 1, 0, 0));
        i_data = 1'b0; strobes(12 * OS);
        check("break_one_frame", nacc - acc0, 1);
        check("break_wait_busy", {31'h0, o_busy}, 32'h1);
        i_data = 1'b1; strobes(2 * OS);
        check("break_released", {31'h0, o_busy}, 32'h0);
        check("break_no_second", nacc - acc0, 1);

        // Reset mid data bit 4 with a frame held in the output register
        i_ready = 1'b0;
        send_frame(16'h0077, 8, 0, 0, 0, 1, 1, 1, 0);
        send_bit(1'b0);
        for (int k = 0; k < 4; k++) send_bit(((8'h5A >> k) & 8'h1) != 0);
        i_data = 1'b1; strobes(4);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        check("mid_reset", {o_valid, o_busy, o_overrun, o_error_parity, o_error_stop_bit,
              o_break, o_data}, 32'h0);
        sb.delete();
        i_ready = 1'b1;
        strobes(2 * OS);
        send_frame(16'h005A, 8, 0, 0, 0, 1, 1, 1, 1);

        // Randomized frames, gapped strobes, random back-pressure
        rand_strobe = 1;
        rand_ready  = 1;
        for (int n = 0; n < 24; n++) begin
            logic [15:0] d;
            logic [15:0] mask;
            int          w, nst;
            bit          pen, odd, pbit, s1, s2;
            d    = 16'($urandom);
            w    = $urandom_range(1, 16);
            pen  = $urandom_range(0, 1) == 1;
            odd  = $urandom_range(0, 1) == 1;
            nst  = $urandom_range(1, 2);
            mask = (w == 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
            pbit = ((^(d & mask)) ^ odd) ^ ($urandom_range(0, 3) == 0);
            s1   = $urandom_range(0, 7) != 0;
            s2   = $urandom_range(0, 7) != 0;
            drain();
            send_frame(d, w, pen, odd, pbit, nst, s1, s2, 1);
        end
        rand_strobe = 0;
        rand_ready  = 0;
        i_ready     = 1'b1;
        drain();
        strobes(4 * OS);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
